// File: rtl/prng_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prng_sequencer
// Description : Single-clock sequencer for the LFSR/mux random-byte datapath.
//               It seeds and steps the LFSRs, latches display bytes at a fixed
//               rate and arbitrates two requesters for extra random bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module prng_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SEL_DIV  = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       EN,
    input  logic [7:0] mux_out,
    input  logic [1:0] req,
    output logic       lfsr_load,
    output logic       lfsr16_en,
    output logic       lfsr8_en,
    output logic [7:0] disp_data,
    output logic       disp_upd,
    output logic       disp_led,
    output logic [1:0] gnt,
    output logic [7:0] rnd_data
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_SEL_W  = (SEL_DIV > 1) ? $clog2(SEL_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_SEL_W-1:0]  c_SEL_LAST  = c_SEL_W'(SEL_DIV - 1);

    typedef enum logic [2:0] {
        c_OFF    = 3'd0,
        c_LOAD   = 3'd1,
        c_RUN    = 3'd2,
        c_STEP_D = 3'd3,
        c_SAMP_D = 3'd4,
        c_STEP_R = 3'd5,
        c_SAMP_R = 3'd6,
        c_ACK    = 3'd7
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt, w_tick_nxt, w_tick_inc;
    logic [c_SEL_W-1:0]  r_sel_cnt, w_sel_nxt, w_sel_inc;
    logic                r_tick_pend, w_pend_nxt;
    logic                r_ptr, w_ptr_nxt;
    logic                r_owner, w_owner_nxt;
    logic                w_tick_tc, w_sel_tc, w_busy;
    logic                w_load_nxt, w_l16_nxt, w_l8_nxt, w_upd_nxt, w_led_nxt;
    logic [1:0]          w_gnt_nxt;
    logic [7:0]          w_disp_nxt, w_rnd_nxt;

    assign w_tick_tc  = (r_tick_cnt == c_TICK_LAST);
    assign w_sel_tc   = (r_sel_cnt == c_SEL_LAST);
    assign w_tick_inc = w_tick_tc ? '0 : r_tick_cnt + 1'b1;
    assign w_sel_inc  = w_sel_tc ? '0 : r_sel_cnt + 1'b1;
    assign w_busy     = (r_state == c_STEP_D) || (r_state == c_SAMP_D) ||
                        (r_state == c_STEP_R) || (r_state == c_SAMP_R) ||
                        (r_state == c_ACK);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_sel_nxt   = r_sel_cnt;
        w_pend_nxt  = r_tick_pend;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_load_nxt  = 1'b0;
        w_l16_nxt   = 1'b0;
        w_l8_nxt    = 1'b0;
        w_upd_nxt   = 1'b0;
        w_gnt_nxt   = 2'b00;
        w_disp_nxt  = disp_data;
        w_led_nxt   = disp_led;
        w_rnd_nxt   = rnd_data;

        if (!EN) begin
            w_state_nxt = c_OFF;
            w_tick_nxt  = '0;
            w_sel_nxt   = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            // Ticks arriving mid-transaction are remembered, merged into one.
            if (w_busy) begin
                w_tick_nxt = w_tick_inc;
                if (w_tick_tc) w_pend_nxt = 1'b1;
            end
            case (r_state)
                c_OFF: begin
                    w_state_nxt = c_LOAD;
                    w_load_nxt  = 1'b1;
                end
                c_LOAD: begin
                    w_tick_nxt  = '0;
                    w_sel_nxt   = '0;
                    w_state_nxt = c_RUN;
                end
                c_RUN: begin
                    w_tick_nxt = w_tick_inc;
                    if (w_tick_tc || r_tick_pend) begin
                        w_pend_nxt  = 1'b0;
                        w_l16_nxt   = 1'b1;
                        w_state_nxt = c_STEP_D;
                    end else if (|req) begin
                        w_owner_nxt = req[r_ptr] ? r_ptr : ~r_ptr;
                        w_l16_nxt   = 1'b1;
                        w_state_nxt = c_STEP_R;
                    end else begin
                        // Select steps only on edges that stay in RUN, so it never
                        // coincides with a data step.
                        w_sel_nxt = w_sel_inc;
                        w_l8_nxt  = w_sel_tc;
                    end
                end
                c_STEP_D: w_state_nxt = c_SAMP_D;
                c_SAMP_D: begin
                    w_disp_nxt  = mux_out;
                    w_upd_nxt   = 1'b1;
                    w_led_nxt   = ~disp_led;
                    w_state_nxt = c_RUN;
                end
                c_STEP_R: w_state_nxt = c_SAMP_R;
                c_SAMP_R: begin
                    w_rnd_nxt          = mux_out;
                    w_gnt_nxt[r_owner] = 1'b1;
                    w_ptr_nxt          = ~r_owner;
                    w_state_nxt        = c_ACK;
                end
                c_ACK:   w_state_nxt = c_RUN;
                default: w_state_nxt = c_OFF;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state     <= c_OFF;
            r_tick_cnt  <= '0;
            r_sel_cnt   <= '0;
            r_tick_pend <= 1'b0;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            lfsr_load   <= 1'b0;
            lfsr16_en   <= 1'b0;
            lfsr8_en    <= 1'b0;
            disp_data   <= 8'h00;
            disp_upd    <= 1'b0;
            disp_led    <= 1'b0;
            gnt         <= 2'b00;
            rnd_data    <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_sel_cnt   <= w_sel_nxt;
            r_tick_pend <= w_pend_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            lfsr_load   <= w_load_nxt;
            lfsr16_en   <= w_l16_nxt;
            lfsr8_en    <= w_l8_nxt;
            disp_data   <= w_disp_nxt;
            disp_upd    <= w_upd_nxt;
            disp_led    <= w_led_nxt;
            gnt         <= w_gnt_nxt;
            rnd_data    <= w_rnd_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/prng_sequencer.md
# prng_sequencer

Single-clock controller for the LFSR/mux random-byte datapath. It replaces the divided-clock scheme with clock-enable pulses in the `CLK` domain. It sequences seeding and stepping of the 16-bit data LFSR and the 8-bit select LFSR, and latches display bytes at a fixed rate. It also arbitrates two on-demand requesters for extra random bytes.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: `CLK` cycles per display update (≥4).
- `SEL_DIV`, 4: `CLK` cycles per select-LFSR step (≥1).

Ports:
- `CLK`, input, 1: system clock, 50 MHz.
- `rst`, input, 1: reset, asynchronous, active-low.
- `EN`, input, 1: synchronous run enable, level.
- `mux_out`, input, 8: combinational output of the 16→8 mux.
- `req`, input, 2: requester byte requests, level.
- `lfsr_load`, output, 1: one-cycle pulse; the datapath loads its seeds.
- `lfsr16_en`, output, 1: one-cycle step enable for the data LFSR.
- `lfsr8_en`, output, 1: one-cycle step enable for the select LFSR.
- `disp_data`, output, 8: latched byte for the 7-segment decoders.
- `disp_upd`, output, 1: one-cycle pulse when `disp_data` changes.
- `disp_led`, output, 1: toggles on every display update.
- `gnt`, output, 2: one-hot one-cycle grant; `rnd_data` is valid while it is high.
- `rnd_data`, output, 8: byte returned to the granted requester.

## Operation
- All outputs are registered. On `rst`=0 every output and internal counter is 0, the state is OFF, and the round-robin pointer is 0.
- States: OFF, LOAD, RUN, STEP_D, SAMP_D, STEP_R, SAMP_R, ACK.
- OFF: all pulses are 0. If `EN`=1 the next state is LOAD.
- LOAD: `lfsr_load`=1 for this cycle. Counters are cleared. The next state is RUN.
- In any state, `EN`=0 sampled at an edge gives state OFF, clears both counters, `tick_pend` and `gnt`, and forces the pulses to 0. `disp_data`, `disp_led` and `rnd_data` keep their values.
- Tick counter:
  - Runs in every state except OFF/LOAD, counting 0..`TICK_DIV`-1 and wrapping.
  - On the terminal count, `tick_pend` is set. In RUN the pending tick is taken at that same edge.
- Select counter:
  - Runs only in RUN, counting 0..`SEL_DIV`-1 and wrapping.
  - On the terminal count, `lfsr8_en`=1 for the next cycle.
  - It is frozen in every other state, so the mux select stays stable while a byte is formed.
- RUN priority, evaluated at each edge:
  1. Tick (terminal count or `tick_pend`): `lfsr16_en`<=1, clear `tick_pend`, go to STEP_D.
  2. Else, if any `req` bit is high: the owner is the requester at the pointer if it is requesting, otherwise the other one. Set `lfsr16_en`<=1 and go to STEP_R.
  3. Else stay in RUN.
- STEP_x: `lfsr16_en` is high during this cycle; it goes to 0 at the edge leaving STEP_x. The next state is SAMP_x.
- SAMP_D: at the exit edge, `disp_data`<=`mux_out`, `disp_upd`<=1, `disp_led` toggles, next state RUN.
- SAMP_R: at the exit edge, `rnd_data`<=`mux_out`, `gnt[owner]`<=1, pointer<=~owner, next state ACK.
- ACK: `gnt` is high this cycle and `req` is ignored. The next state is RUN with `gnt`=0.
- Requester rules:
  - A requester holds `req` until it sees `gnt`.
  - It drops `req` at the edge ending the `gnt` cycle, or keeps it high to ask for another byte.
- `lfsr8_en` and `lfsr16_en` are never high in the same cycle.

## Timing
- From the edge where the tick terminal count is taken in RUN:
  - `lfsr16_en` is high during the next cycle (T+1).
  - `disp_upd` is high in cycle T+3.
- Request latency: `req` sampled high in RUN gives `lfsr16_en` at R+1 and `gnt` at R+3. Back in RUN at R+4.
- Ticks that fall during a request transaction are deferred, never lost. Only one is kept pending; a second terminal count while pending is merged.
- A tick and a request at the same edge: the tick wins, and the request is served at the first RUN edge afterwards.
- With requesters continuously busy, a display update is delayed by at most 4 cycles.
- `EN` dropping mid-transaction: no `gnt` and no `disp_upd` are issued for that transaction.

## Test plan
- Reset and enable, `TICK_DIV`=8, `SEL_DIV`=3:
  - `rst` low gives all outputs 0.
  - Release, then `EN`=1: one `lfsr_load` pulse.
  - `lfsr8_en` every 3 cycles in RUN.
  - `lfsr16_en` then `disp_upd` 2 cycles later, repeating every 8 cycles.
  - `disp_data` equals `mux_out` of the cycle before `disp_upd`.
  - `disp_led` toggles on each `disp_upd`.
- Single request: `req`=01 in an idle RUN cycle gives `lfsr16_en` at +1, `gnt`=01 at +3, and `rnd_data`=`mux_out` (model drives 0xA5).
- Round robin: `req`=11 held gives grants 01, 10, 01, 10, each 4 cycles apart.
- Collision: `req`=10 asserted on the tick edge gives `disp_upd` first, then `gnt`=10. The tick period is unchanged.
- Deferred tick: the tick terminal count lands during STEP_R. `gnt` completes, then `lfsr16_en` fires on the first RUN edge. There is exactly one `disp_upd`.
- Abort: `EN`=0 during SAMP_R gives no `gnt` and all pulses 0 from the next cycle. `disp_data` is held. Re-enabling produces `lfsr_load` again.
